i2c_cmd_sequencer: RTL and testbench

//   Command front-end directly upstream of FSM_i2c_master. Buffers host I2C commands
//   (address, rw, write byte) in a FIFO, launches them one at a time on the master's

---
 rtl/i2c_cmd_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer
// Command front-end for an I2C byte master. Host commands are queued in a small
// FIFO and launched one at a time. Completion is tracked through the master's
// hold line, and each command produces exactly one response (read byte or timeout).
module i2c_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [6:0]                 cmd_addr,
  input  logic                       cmd_rw,
  input  logic [7:0]                 cmd_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [7:0]                 rsp_data,
  output logic                       rsp_err,
  output logic                       m_start,
  output logic [6:0]                 m_address,
  output logic                       m_rw,
  output logic [7:0]                 m_idata,
  input  logic                       m_hold,
  input  logic [7:0]                 m_odata,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_MAX  = {TW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_ACTIVE    = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     fifo_mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            cmd_ready_q;
  logic            m_start_q;
  logic [6:0]      m_address_q;
  logic            m_rw_q;
  logic [7:0]      m_idata_q;
  logic            busy_q;
  logic            rsp_valid_q;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            push_s;
  logic            pop_s;
  logic            tmr_clr_s;
  logic [15:0]     head_s;

  // Pushes are gated by the registered ready, so a full FIFO never accepts even on a pop cycle.
  assign push_s = cmd_valid && cmd_ready_q;
  assign head_s = fifo_mem_q[rd_ptr_q];

  // Sequencer next-state: launch, wait for the master to go busy, wait for it to finish, respond.
  always_comb begin
    state_d    = state_q;
    pop_s      = 1'b0;
    tmr_clr_s  = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        // A hold left over from an aborted transaction blocks the next launch.
        if ((count_q != {CW{1'b0}}) && !m_hold) begin
          state_d = ST_LAUNCH;
          pop_s   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d   = ST_WAIT_BUSY;
        tmr_clr_s = 1'b1;
      end
      ST_WAIT_BUSY: begin
        if (m_hold) begin
          state_d   = ST_ACTIVE;
          tmr_clr_s = 1'b1;
        end else if (tmr_q == TMR_LAST) begin
          state_d    = ST_RESP;
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_ACTIVE: begin
        if (!m_hold) begin
          state_d    = ST_RESP;
          rsp_data_d = m_rw_q ? m_odata : 8'h00;
          rsp_err_d  = 1'b0;
        end else if (tmr_q == TMR_LAST) begin
          state_d    = ST_RESP;
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointer/occupancy and watchdog timer next values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tmr_d    = tmr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // The timer only runs while waiting on the master and saturates instead of wrapping.
    if (tmr_clr_s) begin
      tmr_d = {TW{1'b0}};
    end else if (((state_q == ST_WAIT_BUSY) || (state_q == ST_ACTIVE)) && (tmr_q != TMR_MAX)) begin
      tmr_d = tmr_q + TW'(1);
    end else begin
      tmr_d = tmr_q;
    end
  end

  // Command storage; written only on an accepted push, so the head slot is never overwritten.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= {cmd_addr, cmd_rw, cmd_wdata};
    end
  end

  // State, FIFO control, timer and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      tmr_q       <= {TW{1'b0}};
      cmd_ready_q <= 1'b0;
      m_start_q   <= 1'b0;
      m_address_q <= 7'h00;
      m_rw_q      <= 1'b0;
      m_idata_q   <= 8'h00;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tmr_q       <= tmr_d;
      cmd_ready_q <= (count_d < FULL_CNT);
      m_start_q   <= (state_d == ST_LAUNCH);
      busy_q      <= (state_d != ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      // Master-side command fields change only on a pop and stay put until the next one.
      if (pop_s) begin
        m_address_q <= head_s[15:9];
        m_rw_q      <= head_s[8];
        m_idata_q   <= head_s[7:0];
      end else begin
        m_address_q <= m_address_q;
        m_rw_q      <= m_rw_q;
        m_idata_q   <= m_idata_q;
      end
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign m_start    = m_start_q;
  assign m_address  = m_address_q;
  assign m_rw       = m_rw_q;
  assign m_idata    = m_idata_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Testbench for i2c_cmd_sequencer: directed scenarios plus random traffic, checked
// every cycle against a queue-and-deadline transaction model of the sequencer.
module tb_i2c_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr  = 7'h00;
  logic       cmd_rw    = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       m_start;
  logic [6:0] m_address;
  logic       m_rw;
  logic [7:0] m_idata;
  logic       m_hold    = 1'b0;
  logic [7:0] m_odata   = 8'h00;
  logic       busy;
  logic [2:0] fifo_count;

  i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_start(m_start), .m_address(m_address), .m_rw(m_rw), .m_idata(m_idata),
    .m_hold(m_hold), .m_odata(m_odata),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expired(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // ---------------- master stand-in ----------------
  logic       force_hold = 1'b0;
  logic       respond    = 1'b1;
  int         cfg_dly    = 3;
  int         cfg_len    = 20;
  logic [7:0] cfg_odata  = 8'h00;

  initial begin
    int pre_cnt;
    int run_cnt;
    logic [7:0] lat_odata;
    pre_cnt = 0;
    run_cnt = 0;
    lat_odata = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        pre_cnt = 0;
        run_cnt = 0;
        m_hold  = 1'b0;
        m_odata = 8'h00;
      end else begin
        if (m_start && respond) begin
          pre_cnt   = cfg_dly;
          run_cnt   = cfg_len;
          lat_odata = cfg_odata;
        end else if (pre_cnt > 0) begin
          pre_cnt--;
        end else if (run_cnt > 0) begin
          run_cnt--;
          if (run_cnt == 0) m_odata = lat_odata;
        end
        m_hold = force_hold || (pre_cnt == 0 && run_cnt > 0);
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [6:0] a;
    logic       rw;
    logic [7:0] d;
  } cmd_t;

  cmd_t       q[$];
  cmd_t       cur     = '0;
  int         ph      = 0;   // 0 free, 1 start pulse, 2 awaiting hold, 3 master running, 4 replying
  int         edge_n  = 0;
  int         deadline = 0;
  logic [7:0] e_data  = 8'h00;
  logic       e_err   = 1'b0;
  logic       e_ready = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
        ph      = 0;
        e_ready = 1'b0;
        e_data  = 8'h00;
        e_err   = 1'b0;
        cur     = '0;
      end else begin
        edge_n++;
        if (ph == 0) begin
          if (q.size() > 0 && !m_hold) begin
            cur = q.pop_front();
            ph  = 1;
          end
        end else if (ph == 1) begin
          ph = 2;
          deadline = edge_n + TIMEOUT;
        end else if (ph == 2) begin
          if (m_hold) begin
            ph = 3;
            deadline = edge_n + TIMEOUT;
          end else if (edge_n == deadline) begin
            ph = 4; e_data = 8'h00; e_err = 1'b1;
          end
        end else if (ph == 3) begin
          if (!m_hold) begin
            ph = 4; e_data = cur.rw ? m_odata : 8'h00; e_err = 1'b0;
          end else if (edge_n == deadline) begin
            ph = 4; e_data = 8'h00; e_err = 1'b1;
          end
        end else begin
          if (rsp_ready) ph = 0;
        end
        if (cmd_valid && e_ready) q.push_back({cmd_addr, cmd_rw, cmd_wdata});
        e_ready = (q.size() < DEPTH);
      end
    end
  end

  // ---------------- start pulse log ----------------
  int         n_start = 0;
  logic [6:0] started[$];

  initial begin
    forever begin
      @(posedge clk);
      if (!reset && m_start) begin
        n_start++;
        started.push_back(m_address);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_m_start", m_start, 0);
        chk("rst_m_address", m_address, 0);
        chk("rst_m_rw", m_rw, 0);
        chk("rst_m_idata", m_idata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_count", fifo_count, 0);
      end else begin
        chk("fifo_count", fifo_count, q.size());
        chk("cmd_ready", cmd_ready, e_ready);
        chk("busy", busy, ph != 0);
        chk("m_start", m_start, ph == 1);
        chk("rsp_valid", rsp_valid, ph == 4);
        if (ph == 4) begin
          chk("rsp_data", rsp_data, e_data);
          chk("rsp_err", rsp_err, e_err);
        end
        if (ph != 0) begin
          chk("m_address", m_address, cur.a);
          chk("m_rw", m_rw, cur.rw);
          chk("m_idata", m_idata, cur.d);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [6:0] a, input logic rw, input logic [7:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      expired("push_ready");
    end else begin
      cmd_valid = 1'b1; cmd_addr = a; cmd_rw = rw; cmd_wdata = d;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int bound);
    int n;
    n = 0;
    while (!rsp_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) expired("wait_rsp");
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy || fifo_count != 3'd0 || m_hold) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (busy || fifo_count != 3'd0 || m_hold) expired("wait_idle");
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int n0;
    int k;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    chk("ready_before_first_edge", cmd_ready, 0);
    @(negedge clk);
    chk("ready_after_first_edge", cmd_ready, 1);

    // Write: addr 55, data 55, hold rises 3 cycles after start for 20 cycles.
    respond = 1'b1; cfg_dly = 3; cfg_len = 20; cfg_odata = 8'hEE;
    n0 = n_start;
    push(7'h55, 1'b0, 8'h55);
    chk("wr_count_after_push", fifo_count, 1);
    chk("wr_no_start_yet", m_start, 0);
    @(negedge clk);
    chk("wr_start", m_start, 1);
    chk("wr_addr", m_address, 7'h55);
    chk("wr_idata", m_idata, 8'h55);
    chk("wr_count_after_pop", fifo_count, 0);
    @(negedge clk);
    chk("wr_start_one_cycle", m_start, 0);
    wait_rsp(200);
    chk("wr_rsp_data", rsp_data, 8'h00);
    chk("wr_rsp_err", rsp_err, 0);
    wait_idle(50);
    chk("wr_one_start", n_start - n0, 1);

    // Read: addr 2A, master returns A5.
    cfg_dly = 2; cfg_len = 5; cfg_odata = 8'hA5;
    push(7'h2A, 1'b1, 8'h00);
    wait_rsp(200);
    chk("rd_rsp_data", rsp_data, 8'hA5);
    chk("rd_rsp_err", rsp_err, 0);
    chk("rd_addr", m_address, 7'h2A);
    wait_idle(50);

    // Full FIFO while the master is stuck busy.
    force_hold = 1'b1;
    repeat (2) @(negedge clk);
    started.delete();
    for (int i = 0; i < DEPTH; i++) push(7'(8'h10 + i), 1'b0, 8'(i));
    chk("full_ready_low", cmd_ready, 0);
    chk("full_count", fifo_count, DEPTH);
    cmd_valid = 1'b1; cmd_addr = 7'h14; cmd_rw = 1'b0; cmd_wdata = 8'h04;
    repeat (3) @(negedge clk);
    chk("full_no_overflow", fifo_count, DEPTH);
    cmd_valid = 1'b0;
    cfg_dly = 1; cfg_len = 3;
    force_hold = 1'b0;
    push(7'h14, 1'b0, 8'h04);
    wait_idle(500);
    chk("full_started_n", started.size(), DEPTH + 1);
    for (int i = 0; i < DEPTH + 1 && i < started.size(); i++)
      chk("full_order", started[i], 8'h10 + i);

    // Timeout: hold never rises.
    respond = 1'b0; rsp_ready = 1'b0;
    push(7'h33, 1'b1, 8'h00);
    k = 0;
    while (!m_start && k < 20) begin @(negedge clk); k++; end
    if (!m_start) expired("to_start");
    k = 0;
    while (!rsp_valid && k < 4 * TIMEOUT) begin @(negedge clk); k++; end
    chk("to_latency", k, TIMEOUT + 1);
    chk("to_err", rsp_err, 1);
    chk("to_data", rsp_data, 8'h00);
    force_hold = 1'b1;
    repeat (2) @(negedge clk);
    push(7'h44, 1'b0, 8'h44);
    rsp_ready = 1'b1;
    n0 = n_start;
    repeat (10) @(negedge clk);
    chk("to_no_launch_while_hold", n_start - n0, 0);
    chk("to_queued", fifo_count, 1);
    respond = 1'b1; cfg_dly = 1; cfg_len = 2;
    force_hold = 1'b0;
    wait_idle(300);
    chk("to_launch_after_release", n_start - n0, 1);

    // Backpressure: response held for 10 cycles.
    rsp_ready = 1'b0; cfg_dly = 2; cfg_len = 4; cfg_odata = 8'h3C;
    push(7'h21, 1'b1, 8'h00);
    push(7'h22, 1'b0, 8'h99);
    wait_rsp(200);
    n0 = n_start;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_held", rsp_valid, 1);
      chk("bp_data_held", rsp_data, 8'h3C);
      chk("bp_err_held", rsp_err, 0);
    end
    chk("bp_no_new_start", n_start - n0, 0);
    chk("bp_queued", fifo_count, 1);
    rsp_ready = 1'b1;
    wait_idle(300);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_addr  = 7'($urandom);
      cmd_rw    = 1'($urandom);
      cmd_wdata = 8'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      cfg_dly   = ($urandom_range(0, 9) == 0) ? TIMEOUT + 5 : int'($urandom_range(1, 8));
      cfg_len   = int'($urandom_range(1, 12));
      cfg_odata = 8'($urandom);
      respond   = ($urandom_range(0, 19) != 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b1; respond = 1'b1;
    wait_idle(3000);

    // Reset during ACTIVE with two commands queued.
    cfg_dly = 2; cfg_len = 40;
    push(7'h61, 1'b0, 8'h01);
    push(7'h62, 1'b0, 8'h02);
    push(7'h63, 1'b0, 8'h03);
    k = 0;
    while (!m_hold && k < 20) begin @(negedge clk); k++; end
    if (!m_hold) expired("rst_hold");
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_queued", fifo_count, 2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start", m_start, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    n0 = n_start;
    repeat (30) @(negedge clk);
    chk("post_rst_no_start", n_start - n0, 0);
    chk("post_rst_no_rsp", rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
